// File: rtl/lvdt_sync_demod.sv
`timescale 1ns/1ps
// Synchronous demodulator for the LVDT chain. It decodes a thermometer ADC word and synchronises the excitation.
// It accumulates +/- samples over N_PER excitation periods and reports a saturating window sum and excitation loss.
module lvdt_sync_demod #(
    parameter int N_BITS  = 5,
    parameter int N_PER   = 4,
    parameter int ACC_W   = 16,
    parameter int TIMEOUT = 64,
    localparam int CW     = $clog2(N_BITS + 1)
) (
    input  logic              mclk,
    input  logic              mrst_n,
    input  logic              en,
    input  logic [N_BITS-1:0] adcbits,
    input  logic              inp,
    output logic [CW-1:0]     code,
    output logic              code_err,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    output logic              result_sat,
    output logic              no_exc
);

    localparam int SW = CW + 2;
    localparam int PW = $clog2(N_PER + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic signed [SW-1:0] NB_S = SW'(N_BITS);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_ACC  = 2'd2;

    logic [CW-1:0]        code_q, code_d;
    logic                 code_err_q, code_err_d;
    logic                 dec_zero;
    logic                 sync1_q, sync1_d;
    logic                 inp_s_q, inp_s_d;
    logic                 inp_prev_q, inp_prev_d;
    logic signed [SW-1:0] s_q, s_d;
    logic signed [SW-1:0] demod;
    logic [ACC_W:0]       demod_ext;
    logic [ACC_W:0]       acc_sum;
    logic [ACC_W-1:0]     acc_clamped;
    logic                 clip;
    logic                 rise, any_edge, tmo_hit;

    logic [1:0]           state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [PW-1:0]        per_q, per_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 wsat_q, wsat_d;
    logic [ACC_W-1:0]     result_q, result_d;
    logic                 result_valid_q, result_valid_d;
    logic                 result_sat_q, result_sat_d;
    logic                 no_exc_q, no_exc_d;

    // Level is the run of ones from bit 0; any one above the first zero is a bubble.
    always_comb begin
        code_d     = '0;
        code_err_d = 1'b0;
        dec_zero   = 1'b0;
        for (int i = 0; i < N_BITS; i++) begin
            if (!adcbits[i]) begin
                dec_zero = 1'b1;
            end else if (dec_zero) begin
                code_err_d = 1'b1;
            end else begin
                code_d = CW'(i + 1);
            end
        end
    end

    // The extra sample stage lines s up with inp_s, which trails its input by two edges.
    always_comb begin
        sync1_d    = inp;
        inp_s_d    = sync1_q;
        inp_prev_d = inp_s_q;
        s_d        = $signed({1'b0, code_q, 1'b0}) - NB_S;
        rise       = inp_s_q & ~inp_prev_q;
        any_edge   = inp_s_q ^ inp_prev_q;
        demod      = inp_s_q ? s_q : -s_q;
        demod_ext  = {{(ACC_W + 1 - SW){demod[SW-1]}}, demod};
    end

    always_comb begin
        acc_sum = {acc_q[ACC_W-1], acc_q} + demod_ext;
        clip    = acc_sum[ACC_W] ^ acc_sum[ACC_W-1];
        if (!clip) begin
            acc_clamped = acc_sum[ACC_W-1:0];
        end else if (acc_sum[ACC_W]) begin
            acc_clamped = {1'b1, {(ACC_W - 1){1'b0}}};
        end else begin
            acc_clamped = {1'b0, {(ACC_W - 1){1'b1}}};
        end
    end

    // A rise is always an edge, so it can never coincide with a timeout hit.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        per_d          = per_q;
        tmo_d          = tmo_q;
        wsat_d         = wsat_q;
        result_d       = result_q;
        result_sat_d   = result_sat_q;
        result_valid_d = 1'b0;
        no_exc_d       = no_exc_q & ~rise;
        tmo_hit        = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            per_d   = '0;
            tmo_d   = '0;
            wsat_d  = 1'b0;
        end else begin
            if (state_q != ST_IDLE) begin
                if (any_edge) begin
                    tmo_d = '0;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    tmo_d    = '0;
                    tmo_hit  = 1'b1;
                    no_exc_d = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ARM;
                    acc_d   = '0;
                    per_d   = '0;
                    tmo_d   = '0;
                    wsat_d  = 1'b0;
                end
                ST_ARM: begin
                    if (rise) begin
                        acc_d   = demod_ext[ACC_W-1:0];
                        per_d   = '0;
                        wsat_d  = 1'b0;
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (tmo_hit) begin
                        acc_d   = '0;
                        per_d   = '0;
                        wsat_d  = 1'b0;
                        state_d = ST_ARM;
                    end else if (rise && per_q == PW'(N_PER - 1)) begin
                        result_d       = acc_q;
                        result_sat_d   = wsat_q;
                        result_valid_d = 1'b1;
                        acc_d          = demod_ext[ACC_W-1:0];
                        per_d          = '0;
                        wsat_d         = 1'b0;
                    end else begin
                        acc_d  = acc_clamped;
                        wsat_d = wsat_q | clip;
                        if (rise) begin
                            per_d = per_q + 1'b1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            code_q         <= '0;
            code_err_q     <= 1'b0;
            sync1_q        <= 1'b0;
            inp_s_q        <= 1'b0;
            inp_prev_q     <= 1'b0;
            s_q            <= '0;
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            per_q          <= '0;
            tmo_q          <= '0;
            wsat_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_sat_q   <= 1'b0;
            no_exc_q       <= 1'b0;
        end else begin
            code_q         <= code_d;
            code_err_q     <= code_err_d;
            sync1_q        <= sync1_d;
            inp_s_q        <= inp_s_d;
            inp_prev_q     <= inp_prev_d;
            s_q            <= s_d;
            state_q        <= state_d;
            acc_q          <= acc_d;
            per_q          <= per_d;
            tmo_q          <= tmo_d;
            wsat_q         <= wsat_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_sat_q   <= result_sat_d;
            no_exc_q       <= no_exc_d;
        end
    end

    assign code         = code_q;
    assign code_err     = code_err_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_sat   = result_sat_q;
    assign no_exc       = no_exc_q;

endmodule

// File: tb/tb_lvdt_sync_demod.sv
`timescale 1ns/1ps
// Bench for lvdt_sync_demod: a wide and a narrow accumulator instance share one stimulus stream.
// Both are compared every cycle against a reference built from the input history.
module tb_lvdt_sync_demod;

    localparam int N_BITS  = 5;
    localparam int N_PER   = 4;
    localparam int TIMEOUT = 64;
    localparam int ACC_A   = 16;
    localparam int ACC_B   = 8;

    logic       mclk = 1'b0;
    logic       mrst_n;
    logic       en;
    logic [4:0] adcbits;
    logic       inp;

    logic [2:0]  code_a, code_b;
    logic        code_err_a, code_err_b;
    logic [15:0] result_a;
    logic [7:0]  result_b;
    logic        valid_a, valid_b, sat_a, sat_b, no_exc_a, no_exc_b;

    int checks = 0;
    int errors = 0;

    // Reference state: input history plus window bookkeeping for both accumulator widths.
    logic [3:0] inp_hist;
    logic [4:0] adc_hist [3];
    int  acc_width [2] = '{ACC_A, ACC_B};
    int  m_state, m_cnt, m_tmo, m_code;
    int  m_acc [2];
    int  m_res [2];
    bit  m_sat [2];
    bit  m_res_sat [2];
    bit  m_valid, m_no_exc, m_err;

    int phase_cnt, hi_len, lo_len;
    int strobes;
    int last_res_a, last_res_b;
    bit last_sat_a, last_sat_b;

    lvdt_sync_demod #(.N_BITS(N_BITS), .N_PER(N_PER), .ACC_W(ACC_A), .TIMEOUT(TIMEOUT)) dut_a (
        .mclk(mclk), .mrst_n(mrst_n), .en(en), .adcbits(adcbits), .inp(inp),
        .code(code_a), .code_err(code_err_a), .result(result_a), .result_valid(valid_a),
        .result_sat(sat_a), .no_exc(no_exc_a)
    );

    lvdt_sync_demod #(.N_BITS(N_BITS), .N_PER(N_PER), .ACC_W(ACC_B), .TIMEOUT(TIMEOUT)) dut_b (
        .mclk(mclk), .mrst_n(mrst_n), .en(en), .adcbits(adcbits), .inp(inp),
        .code(code_b), .code_err(code_err_b), .result(result_b), .result_valid(valid_b),
        .result_sat(sat_b), .no_exc(no_exc_b)
    );

    always #5 mclk = ~mclk;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int therm_level(input logic [4:0] w);
        int n = 0;
        while (n < N_BITS && w[n]) n++;
        return n;
    endfunction

    function automatic bit therm_bubble(input logic [4:0] w);
        int n = therm_level(w);
        return (w >> n) != 0;
    endfunction

    function automatic int clamp_to(input int v, input int w, output bit hit);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        hit = 1'b0;
        if (v > hi) begin hit = 1'b1; return hi; end
        if (v < lo) begin hit = 1'b1; return lo; end
        return v;
    endfunction

    function automatic logic [4:0] random_adc();
        int lvl;
        if ($urandom_range(0, 7) == 0) return 5'($urandom);
        lvl = $urandom_range(0, N_BITS);
        return 5'((1 << lvl) - 1);
    endfunction

    task automatic model_reset();
        inp_hist = '0;
        for (int k = 0; k < 3; k++) adc_hist[k] = '0;
        m_state = 0; m_cnt = 0; m_tmo = 0; m_code = 0;
        m_valid = 0; m_no_exc = 0; m_err = 0;
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0; m_res[k] = 0; m_sat[k] = 0; m_res_sat[k] = 0;
        end
    endtask

    // Decisions at an edge use the sample and phase from two edges earlier (synchroniser latency).
    task automatic model_step();
        int  s_al, d_al;
        bit  phase, rise, any_edge, timed_out, hit;
        inp_hist    = {inp_hist[2:0], inp};
        adc_hist[2] = adc_hist[1];
        adc_hist[1] = adc_hist[0];
        adc_hist[0] = adcbits;
        phase    = inp_hist[2];
        rise     = inp_hist[2] && !inp_hist[3];
        any_edge = inp_hist[2] != inp_hist[3];
        s_al = 2 * therm_level(adc_hist[2]) - N_BITS;
        d_al = phase ? s_al : -s_al;
        m_valid = 0;
        timed_out = 0;
        if (rise) m_no_exc = 0;
        if (!en) begin
            m_state = 0; m_cnt = 0; m_tmo = 0;
            for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_sat[k] = 0; end
        end else if (m_state == 0) begin
            m_state = 1;
        end else begin
            if (any_edge) m_tmo = 0;
            else if (m_tmo + 1 == TIMEOUT) begin m_tmo = 0; timed_out = 1; m_no_exc = 1; end
            else m_tmo++;
            if (m_state == 1) begin
                if (rise) begin
                    m_state = 2; m_cnt = 0;
                    for (int k = 0; k < 2; k++) begin m_acc[k] = d_al; m_sat[k] = 0; end
                end
            end else if (timed_out) begin
                m_state = 1; m_cnt = 0;
                for (int k = 0; k < 2; k++) begin m_acc[k] = 0; m_sat[k] = 0; end
            end else if (rise && m_cnt + 1 == N_PER) begin
                m_valid = 1; m_cnt = 0;
                for (int k = 0; k < 2; k++) begin
                    m_res[k] = m_acc[k]; m_res_sat[k] = m_sat[k];
                    m_acc[k] = d_al; m_sat[k] = 0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    m_acc[k] = clamp_to(m_acc[k] + d_al, acc_width[k], hit);
                    if (hit) m_sat[k] = 1;
                end
                if (rise) m_cnt++;
            end
        end
        m_code = therm_level(adcbits);
        m_err  = therm_bubble(adcbits);
    endtask

    task automatic check_cycle();
        checkOutput("code_a", int'(code_a), m_code);
        checkOutput("code_b", int'(code_b), m_code);
        checkOutput("code_err_a", int'(code_err_a), int'(m_err));
        checkOutput("code_err_b", int'(code_err_b), int'(m_err));
        checkOutput("valid_a", int'(valid_a), int'(m_valid));
        checkOutput("valid_b", int'(valid_b), int'(m_valid));
        checkOutput("result_a", int'($signed(result_a)), m_res[0]);
        checkOutput("result_b", int'($signed(result_b)), m_res[1]);
        checkOutput("sat_a", int'(sat_a), int'(m_res_sat[0]));
        checkOutput("sat_b", int'(sat_b), int'(m_res_sat[1]));
        checkOutput("no_exc_a", int'(no_exc_a), int'(m_no_exc));
        checkOutput("no_exc_b", int'(no_exc_b), int'(m_no_exc));
        if (valid_a) begin
            strobes++;
            last_res_a = int'($signed(result_a));
            last_res_b = int'($signed(result_b));
            last_sat_a = sat_a;
            last_sat_b = sat_b;
        end
    endtask

    // Called at a falling edge: drive, let the rising edge happen, then sample at the next falling edge.
    task automatic applyStimulus(input logic [4:0] adc, input logic inp_v, input logic en_v);
        adcbits = adc;
        inp     = inp_v;
        en      = en_v;
        @(posedge mclk);
        model_step();
        @(negedge mclk);
        check_cycle();
    endtask

    task automatic wave_step(input logic [4:0] hi_adc, input logic [4:0] lo_adc, input logic en_v);
        logic inp_v;
        if (phase_cnt >= hi_len + lo_len) phase_cnt = 0;
        inp_v = (phase_cnt < hi_len);
        phase_cnt++;
        applyStimulus(inp_v ? hi_adc : lo_adc, inp_v, en_v);
    endtask

    task automatic run_wave(input int n, input logic [4:0] hi_adc, input logic [4:0] lo_adc);
        for (int i = 0; i < n; i++) wave_step(hi_adc, lo_adc, 1'b1);
    endtask

    task automatic run_random(input int n);
        logic inp_v, en_v;
        for (int i = 0; i < n; i++) begin
            if (phase_cnt >= hi_len + lo_len) begin
                phase_cnt = 0;
                hi_len = $urandom_range(3, 14);
                lo_len = $urandom_range(3, 14);
            end
            inp_v = (phase_cnt < hi_len);
            phase_cnt++;
            en_v = ($urandom_range(0, 249) != 0);
            applyStimulus(random_adc(), inp_v, en_v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        checkOutput({tag, "_code"}, int'(code_a), 0);
        checkOutput({tag, "_code_err"}, int'(code_err_a), 0);
        checkOutput({tag, "_result_a"}, int'(result_a), 0);
        checkOutput({tag, "_result_b"}, int'(result_b), 0);
        checkOutput({tag, "_valid"}, int'(valid_a), 0);
        checkOutput({tag, "_sat_b"}, int'(sat_b), 0);
        checkOutput({tag, "_no_exc"}, int'(no_exc_a), 0);
    endtask

    initial begin
        mrst_n = 1'b0; en = 1'b0; adcbits = '0; inp = 1'b0;
        phase_cnt = 0; hi_len = 10; lo_len = 10; strobes = 0;
        last_res_a = 0; last_res_b = 0; last_sat_a = 0; last_sat_b = 0;
        model_reset();
        #2;
        check_reset_outputs("por");
        @(negedge mclk);
        @(negedge mclk);
        mrst_n = 1'b1;

        $display("[TB] constant input 00111");
        strobes = 0;
        run_wave(400, 5'b00111, 5'b00111);
        checkOutput("const_code", int'(code_a), 3);
        checkOutput("const_result", last_res_a, 0);
        checkOutput("const_sat", int'(last_sat_a), 0);
        checkOutput("const_strobes", strobes, 4);

        $display("[TB] phase-locked 11111/00001");
        run_wave(400, 5'b11111, 5'b00001);
        checkOutput("locked_result_a", last_res_a, 320);
        checkOutput("locked_sat_a", int'(last_sat_a), 0);
        checkOutput("locked_result_b", last_res_b, 127);
        checkOutput("locked_sat_b", int'(last_sat_b), 1);

        $display("[TB] phase-locked 11111/00000");
        run_wave(400, 5'b11111, 5'b00000);
        checkOutput("full_result_a", last_res_a, 400);
        checkOutput("full_sat_a", int'(last_sat_a), 0);
        checkOutput("full_result_b", last_res_b, 127);
        checkOutput("full_sat_b", int'(last_sat_b), 1);

        $display("[TB] bubble code");
        wave_step(5'b01011, 5'b01011, 1'b1);
        checkOutput("bubble_code", int'(code_a), 2);
        checkOutput("bubble_err", int'(code_err_a), 1);
        wave_step(5'b00011, 5'b00011, 1'b1);
        checkOutput("clean_code", int'(code_a), 2);
        checkOutput("clean_err", int'(code_err_a), 0);

        $display("[TB] enable drop mid-window");
        run_wave(37, 5'b11111, 5'b00001);
        wave_step(5'b11111, 5'b00001, 1'b0);
        run_wave(200, 5'b11111, 5'b00001);

        $display("[TB] excitation loss");
        while (phase_cnt != hi_len + 3) wave_step(5'b00111, 5'b00111, 1'b1);
        strobes = 0;
        for (int i = 0; i < 100; i++) applyStimulus(5'b00111, 1'b0, 1'b1);
        checkOutput("loss_no_exc", int'(no_exc_a), 1);
        checkOutput("loss_strobes", strobes, 0);
        phase_cnt = 0;
        run_wave(120, 5'b11111, 5'b00001);
        checkOutput("resume_no_exc", int'(no_exc_a), 0);
        checkOutput("resume_strobes", strobes, 1);
        checkOutput("resume_result_a", last_res_a, 320);

        $display("[TB] reset mid-window");
        run_wave(50, 5'b11111, 5'b00001);
        #2 mrst_n = 1'b0;
        #1 check_reset_outputs("mid");
        model_reset();
        @(negedge mclk);
        @(negedge mclk);
        mrst_n = 1'b1;
        strobes = 0;
        phase_cnt = 0;
        run_wave(100, 5'b11111, 5'b00001);
        checkOutput("post_reset_strobes", strobes, 1);

        $display("[TB] randomised traffic");
        run_random(1500);
        for (int i = 0; i < 90; i++) applyStimulus(random_adc(), inp, 1'b1);
        run_random(1500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
